// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, pixel widths and write-controller state encoding
package fb_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int X_WIDTH = 10;
  localparam int Y_WIDTH = 10;
  localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;
  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: 2-way round-robin arbiter (clock, reset, en, valid[1:0] -> one-hot grant[1:0]); the loser of the last accepted grant wins ties
module fb_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;
  always_comb begin
    grant[0] = en && valid[0] && (!valid[1] || last);
    grant[1] = en && valid[1] && (!valid[0] || !last);
  end
  always_ff @(posedge clock)
    last <= reset ? 1'b1 : |grant ? grant[1] : last;
endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: frame-buffer write port shared by two valid/ready pixel requesters (reqN_*) plus a full-screen clear engine (clear_*), driving buf_we/buf_in_address/buf_in_data
module fb_write_ctrl #(
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int X_WIDTH = fb_pkg::X_WIDTH,
  parameter int Y_WIDTH = fb_pkg::Y_WIDTH,
  parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH,
  parameter int X_MAX = fb_pkg::X_MAX,
  parameter int Y_MAX = fb_pkg::Y_MAX
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  clear_busy,
  input  logic                  req0_valid,
  input  logic [X_WIDTH-1:0]    req0_x,
  input  logic [Y_WIDTH-1:0]    req0_y,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [X_WIDTH-1:0]    req1_x,
  input  logic [Y_WIDTH-1:0]    req1_y,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_in_address,
  output logic [DATA_WIDTH-1:0] buf_in_data
);
  import fb_pkg::*;
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_MAX - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_MAX - 1);
  state_t state, state_n;
  logic [X_WIDTH-1:0] cx, wx;
  logic [Y_WIDTH-1:0] cy, wy;
  logic [DATA_WIDTH-1:0] color, wd;
  logic [1:0] grant;
  logic sweep, last, in_range;
  fb_rr_arbiter u_arb (
    .clock(clock),
    .reset(reset),
    .en(!sweep),
    .valid({req1_valid, req0_valid}),
    .grant(grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  // cx/cy always hold the next sweep position and rest at 0 in IDLE, so the start cycle issues address 0
  always_comb begin
    sweep = state == CLEAR || clear_start;
    last = cx == X_LAST && cy == Y_LAST;
    state_n = sweep && !last ? CLEAR : IDLE;
    wx = grant[1] ? req1_x : req0_x;
    wy = grant[1] ? req1_y : req0_y;
    wd = grant[1] ? req1_data : req0_data;
    in_range = wx <= X_LAST && wy <= Y_LAST;
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_busy <= 1'b0;
      buf_we <= 1'b0;
      buf_in_address <= '0;
      buf_in_data <= '0;
      cx <= '0;
      cy <= '0;
      color <= '0;
    end else if (sweep) begin
      clear_busy <= 1'b1;
      buf_we <= 1'b1;
      buf_in_address <= {cy, cx};
      buf_in_data <= state == CLEAR ? color : clear_color;
      if (state == IDLE) color <= clear_color;
      cx <= cx == X_LAST ? '0 : cx + X_WIDTH'(1);
      cy <= cx != X_LAST ? cy : last ? '0 : cy + Y_WIDTH'(1);
    end else begin
      clear_busy <= 1'b0;
      buf_we <= |grant && in_range;
      if (|grant) begin
        buf_in_address <= {wy, wx};
        buf_in_data <= wd;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: scoreboard bench for fb_write_ctrl on a reduced 8x6 screen
module tb_fb_write_ctrl;
  localparam int XM = 8;
  localparam int YM = 6;
  localparam int N = XM * YM;
  typedef struct {int cyc; int addr; int data;} wr_t;
  logic clock = 0, reset = 1, clear_start = 0;
  logic [11:0] clear_color = 0, req0_data = 0, req1_data = 0, buf_in_data;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready, clear_busy, buf_we;
  logic [9:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
  logic [19:0] buf_in_address;
  int checks = 0, errors = 0, cyc = 0;
  int blk_end = -1, busy_lo = 1, busy_hi = 0, last_win = 1;
  wr_t q[$];

  fb_write_ctrl #(.DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10), .ADDR_WIDTH(20), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data), .req1_ready(req1_ready),
    .buf_we(buf_we), .buf_in_address(buf_in_address), .buf_in_data(buf_in_data)
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // reference model: decides who should be ready and which writes must appear, from the behavioural rules
  always @(negedge clock) begin
    #1;
    if (reset) begin
      while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
      if (busy_hi > cyc) busy_hi = cyc;
      blk_end = -1;
      last_win = 1;
    end else begin
      int win;
      bit blocked;
      blocked = cyc <= blk_end;
      win = -1;
      if (!blocked && !clear_start) begin
        if (req0_valid && req1_valid) win = 1 - last_win;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end
      chk("ready0", req0_ready, win == 0);
      chk("ready1", req1_ready, win == 1);
      if (win >= 0) begin
        int x, y;
        last_win = win;
        x = win ? req1_x : req0_x;
        y = win ? req1_y : req0_y;
        if (x < XM && y < YM) q.push_back('{cyc + 1, y * 1024 + x, win ? req1_data : req0_data});
      end
      if (!blocked && clear_start) begin
        for (int n = 0; n < N; n++) q.push_back('{cyc + 1 + n, (n / XM) * 1024 + n % XM, clear_color});
        blk_end = cyc + N - 1;
        busy_lo = cyc + 1;
        busy_hi = cyc + N;
      end
    end
  end

  // monitor: compares whatever the buffer port shows against the scoreboard head
  always @(negedge clock) begin
    bit exp_we;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("lost_write", q[0].addr, 32'hffffffff);
      void'(q.pop_front());
    end
    exp_we = q.size() > 0 && q[0].cyc == cyc;
    chk("buf_we", buf_we, exp_we);
    if (exp_we) begin
      wr_t e;
      e = q.pop_front();
      chk("buf_addr", buf_in_address, e.addr);
      chk("buf_data", buf_in_data, e.data);
    end
    chk("clear_busy", clear_busy, cyc >= busy_lo && cyc <= busy_hi);
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    clear_start = 0;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  function automatic logic [9:0] pick(input int lim);
    return $urandom_range(0, 9) == 0 ? 10'($urandom_range(lim, 1023)) : 10'($urandom_range(0, lim - 1));
  endfunction

  task automatic rand_px();
    req0_x = pick(XM); req0_y = pick(YM); req0_data = 12'($urandom);
    req1_x = pick(XM); req1_y = pick(YM); req1_data = 12'($urandom);
  endtask

  initial begin
    repeat (3) next();
    reset = 0;
    @(negedge clock);
    chk("reset_addr", buf_in_address, 0);
    chk("reset_data", buf_in_data, 0);
    next();
    req0_valid = 1; req0_x = 5; req0_y = 3; req0_data = 12'hF00;
    next();
    idle_in();
    next();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_x = 10'(i); req0_y = 1; req0_data = 12'(16 + i);
      req1_x = 10'(i); req1_y = 2; req1_data = 12'(32 + i);
      next();
    end
    idle_in();
    req1_valid = 1; req1_x = 640; req1_y = 0; req1_data = 12'hABC;
    next();
    idle_in();
    next();
    clear_start = 1; clear_color = 12'h0AA; req0_valid = 1; req0_x = 1; req0_y = 1;
    next();
    clear_start = 0;
    for (int i = 0; i < N + 3; i++) begin
      clear_color = 12'($urandom);
      clear_start = $urandom_range(0, 7) == 0;
      next();
    end
    idle_in();
    next();
    clear_start = 1; clear_color = 12'h5A5; req1_valid = 1; req1_x = 2; req1_y = 4; req1_data = 12'h777;
    next();
    clear_start = 0;
    for (int i = 0; i < N + 2; i++) next();
    idle_in();
    next();
    clear_start = 1; clear_color = 12'h123;
    next();
    clear_start = 0;
    next();
    next();
    reset = 1;
    next();
    reset = 0;
    repeat (3) next();
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 199) == 0;
      clear_start = !reset && $urandom_range(0, 99) == 0;
      clear_color = 12'($urandom);
      req0_valid = !reset && $urandom_range(0, 2) != 0;
      req1_valid = !reset && $urandom_range(0, 2) != 0;
      rand_px();
      next();
    end
    reset = 0;
    idle_in();
    repeat (N + 5) next();
    @(negedge clock);
    #2;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
